pc_sequencer: RTL

//   Parametrised program-counter unit: holds the architectural PC and selects next PC

---
 rtl/pc_sequencer_pkg.sv | 13 +
 rtl/pc_sequencer_ras_stack.sv | 48 ++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and next-PC select encoding for the PC sequencer.
package pc_defs;
  localparam int unsigned ADDR_W_DEF   = 64;
  localparam int unsigned INC_DEF      = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_RET = 2'd3
  } pc_sel_e;
endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty does nothing.
module ras_stack #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // r_wp is the next free slot; once full it also points at the oldest entry.
  assign top     = r_mem[r_wp - PW'(1)];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_count <= '0;
    end else if (pop) begin
      if (!w_empty) begin
        r_wp    <= r_wp - PW'(1);
        r_count <= r_count - CW'(1);
      end
    end else if (push) begin
      r_wp <= r_wp + PW'(1);
      if (!w_full) r_count <= r_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop) r_mem[r_wp] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: prioritised next-PC selection (ret > call > jump >
// branch > sequential) with an internal return-address stack.
module pc_sequencer
  import pc_defs::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       INC       = INC_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_off,
  input  logic                       jump,
  input  logic                       call,
  input  logic [ADDR_W-1:0]          jump_target,
  input  logic                       ret,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_next,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_br;
  logic [ADDR_W-1:0] w_ras_top;
  logic [CW-1:0]     w_ras_count;
  pc_sel_e           w_sel;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;

  // Adders wrap modulo 2^ADDR_W; a negative offset is just its two's complement.
  assign w_pc_inc = r_pc + ADDR_W'(INC);
  assign w_pc_br  = r_pc + branch_off;

  always_comb begin
    w_sel     = SEL_SEQ;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (ret) begin
      if (w_ras_count != '0) begin
        w_sel = SEL_RET;
        w_pop = 1'b1;
      end else begin
        w_unf_set = 1'b1;
      end
    end else if (call) begin
      w_sel     = SEL_JMP;
      w_push    = 1'b1;
      w_ovf_set = (w_ras_count == CW'(RAS_DEPTH));
    end else if (jump) begin
      w_sel = SEL_JMP;
    end else if (branch_taken) begin
      w_sel = SEL_BR;
    end
  end

  always_comb begin
    case (w_sel)
      SEL_BR:  pc_next = w_pc_br;
      SEL_JMP: pc_next = jump_target;
      SEL_RET: pc_next = w_ras_top;
      default: pc_next = w_pc_inc;
    endcase
  end

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (en && w_push),
    .pop       (en && w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .count     (w_ras_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (en) begin
      r_pc <= pc_next;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  assign pc            = r_pc;
  assign ras_count     = w_ras_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
endmodule
